// File: rtl/gray_codec_pipe.sv
// Two-stage valid/ready Gray codec: S1 captures the input, S2 holds the converted result.
// Decoded codes are checked for single-bit adjacency against the previous decoded code.
module gray_codec_pipe #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 clr_hist,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_mode,
    output logic                 out_adj_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic             s1_valid;
    logic             s1_mode;
    logic [WIDTH-1:0] s1_data;
    logic             s2_valid;
    logic [WIDTH-1:0] hist;
    logic             hist_valid;

    logic             in_xfer;
    logic             s2_load;
    logic             adj_err;
    logic [WIDTH-1:0] dec_data;
    logic [WIDTH-1:0] enc_data;
    logic [WIDTH-1:0] hist_diff;
    logic [5:0]       diff_ones;

    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign out_valid = s2_valid;

    // Binary bit i is the XOR of Gray bits i..MSB; written this way to avoid a bit-to-bit comb chain.
    always_comb begin
        dec_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_data[i] = ^(s1_data >> i);
        end
    end

    assign enc_data  = s1_data ^ (s1_data >> 1);
    assign hist_diff = s1_data ^ hist;

    always_comb begin
        diff_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff_ones = diff_ones + 6'(hist_diff[i]);
        end
    end

    // A clr_hist pulse on the move edge makes this item the first of a fresh history.
    assign adj_err = !s1_mode && hist_valid && !clr_hist && (diff_ones != 6'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_data  <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_mode  <= in_mode;
            s1_data  <= in_data;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            out_data    <= '0;
            out_mode    <= 1'b0;
            out_adj_err <= 1'b0;
        end else if (s2_load) begin
            s2_valid    <= 1'b1;
            out_data    <= s1_mode ? enc_data : dec_data;
            out_mode    <= s1_mode;
            out_adj_err <= adj_err;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist       <= '0;
            hist_valid <= 1'b0;
        end else if (s2_load && !s1_mode) begin
            hist       <= s1_data;
            hist_valid <= 1'b1;
        end else if (clr_hist) begin
            hist_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (s2_load && adj_err && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Directed bench for gray_codec_pipe: vector table plus backpressure and reset sequences.
// A second instance with a 2-bit error counter sees the same stimulus to exercise saturation.
module tb_gray_codec_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_mode;
    logic [3:0] in_data;
    logic       clr_hist;
    logic       out_ready;

    logic       in_ready,  in_ready_s;
    logic       out_valid, out_valid_s;
    logic [3:0] out_data,  out_data_s;
    logic       out_mode,  out_mode_s;
    logic       out_adj_err, out_adj_err_s;
    logic [7:0] err_count;
    logic [1:0] err_count_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gray_codec_pipe #(.WIDTH(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .clr_hist(clr_hist),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .out_adj_err(out_adj_err), .err_count(err_count)
    );

    gray_codec_pipe #(.WIDTH(4), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_mode(in_mode), .in_data(in_data), .clr_hist(clr_hist),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_mode(out_mode_s), .out_adj_err(out_adj_err_s), .err_count(err_count_s)
    );

    typedef struct packed {
        logic       mode;
        logic [3:0] data;
        logic       clr;
        logic [3:0] exp_data;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends one item through an otherwise empty pipeline; clr is pulsed on the S1->S2 edge.
    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] sat_exp;
        sat_exp     = (v.exp_cnt > 8'd3) ? 8'd3 : v.exp_cnt;
        in_valid    = 1'b1;
        in_mode     = v.mode;
        in_data     = v.data;
        out_ready   = 1'b1;
        #1;
        check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr_hist = v.clr;
        @(negedge clk);
        check($sformatf("v%0d early_valid", idx), 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        clr_hist = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'd1);
        check($sformatf("v%0d out_data", idx), 32'(out_data), 32'(v.exp_data));
        check($sformatf("v%0d out_mode", idx), 32'(out_mode), 32'(v.mode));
        check($sformatf("v%0d adj_err", idx), 32'(out_adj_err), 32'(v.exp_err));
        check($sformatf("v%0d err_count", idx), 32'(err_count), 32'(v.exp_cnt));
        check($sformatf("v%0d err_count_sat", idx), 32'(err_count_s), 32'(sat_exp));
        @(posedge clk);
        #1;
    endtask

    logic [3:0] bp_items[3];
    logic [3:0] bp_exp[3];
    logic [3:0] got_q[$];
    int         got_cyc[$];

    initial begin
        //            mode  data     clr   exp     err   cnt
        vecs[0]  = '{1'b0, 4'b1011, 1'b0, 4'b1101, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 4'b1101, 1'b0, 4'b1011, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 4'b0011, 1'b0, 4'b0010, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 4'b0010, 1'b0, 4'b0011, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 4'b0111, 1'b0, 4'b0101, 1'b1, 8'd1};
        vecs[7]  = '{1'b0, 4'b0111, 1'b0, 4'b0101, 1'b1, 8'd2};
        vecs[8]  = '{1'b0, 4'b1000, 1'b1, 4'b1111, 1'b0, 8'd2};
        vecs[9]  = '{1'b0, 4'b1001, 1'b0, 4'b1110, 1'b0, 8'd2};
        vecs[10] = '{1'b1, 4'b0110, 1'b0, 4'b0101, 1'b0, 8'd2};
        vecs[11] = '{1'b0, 4'b1011, 1'b0, 4'b1101, 1'b0, 8'd2};
        vecs[12] = '{1'b0, 4'b1011, 1'b0, 4'b1101, 1'b1, 8'd3};
        vecs[13] = '{1'b0, 4'b0100, 1'b0, 4'b0111, 1'b1, 8'd4};
        vecs[14] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'd4};
        vecs[15] = '{1'b0, 4'b1111, 1'b0, 4'b1010, 1'b1, 8'd5};

        bp_items[0] = 4'b0001; bp_exp[0] = 4'b0001;
        bp_items[1] = 4'b0010; bp_exp[1] = 4'b0011;
        bp_items[2] = 4'b0011; bp_exp[2] = 4'b0010;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        clr_hist  = 1'b0;
        out_ready = 1'b1;
        #2;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst out_adj_err", 32'(out_adj_err), 32'd0);
        check("rst err_count", 32'(err_count), 32'd0);
        #5;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: three encode items offered while the sink stalls for six cycles.
        begin
            int idx;
            idx = 0;
            for (int cyc = 0; cyc < 14; cyc++) begin
                logic acc;
                in_valid  = (idx < 3);
                in_mode   = 1'b1;
                in_data   = (idx < 3) ? bp_items[idx] : 4'b0000;
                out_ready = (cyc >= 6);
                #1;
                acc = in_valid && in_ready;
                if (out_valid && out_ready) begin
                    got_q.push_back(out_data);
                    got_cyc.push_back(cyc);
                end
                if (cyc >= 2 && cyc <= 5) begin
                    check($sformatf("bp hold c%0d out_data", cyc), 32'(out_data), 32'(bp_exp[0]));
                end
                if (cyc == 5) begin
                    check("bp accepted", 32'(idx), 32'd2);
                    check("bp in_ready", 32'(in_ready), 32'd0);
                    check("bp out_valid", 32'(out_valid), 32'd1);
                end
                @(posedge clk);
                #1;
                if (acc) idx++;
            end
            in_valid = 1'b0;
            check("bp count", 32'(got_q.size()), 32'd3);
            for (int k = 0; k < 3; k++) begin
                if (k < got_q.size()) begin
                    check($sformatf("bp order %0d", k), 32'(got_q[k]), 32'(bp_exp[k]));
                    check($sformatf("bp cycle %0d", k), 32'(got_cyc[k]), 32'(6 + k));
                end
            end
            check("bp drained", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b1;
        in_data   = 4'b0101;
        @(posedge clk);
        #1;
        in_data = 4'b0110;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre-rst in_ready", 32'(in_ready), 32'd0);
        check("pre-rst err_count", 32'(err_count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst err_count", 32'(err_count), 32'd0);
        check("async rst err_count_sat", 32'(err_count_s), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd1);
        check("async rst out_data", 32'(out_data), 32'd0);
        #2;
        rst = 1'b0;
        run_vec('{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 8'd0}, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gray_codec_pipe.md
# gray_codec_pipe

Parametrised, pipelined Gray-code codec that generalises the 3-bit combinational Gray decoder to any width. Each transaction selects a direction: Gray→binary decode or binary→Gray encode. The block adds a valid/ready stream interface with backpressure and checks that consecutive decoded Gray codes are adjacent. It sits between a position/counter source (encoder wheel, async-FIFO pointer) and binary consumers.

## Interface
- WIDTH, 4, code width in bits; legal range 2..32
- ERR_CNT_W, 8, width of the saturating adjacency-error counter
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input transaction present
- in_ready  out  1  block accepts input this cycle
- in_mode  in  1  0 = decode Gray→binary, 1 = encode binary→Gray
- in_data  in  WIDTH  code to convert
- clr_hist  in  1  single-cycle pulse; forget the adjacency history
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result this cycle
- out_data  out  WIDTH  converted code
- out_mode  out  1  in_mode of this result
- out_adj_err  out  1  decode result not adjacent to previous decoded input
- err_count  out  ERR_CNT_W  saturating count of adjacency errors

## Operation
- Two register stages: S1 (input capture) and S2 (output register). Conversion logic sits between S1 and S2.
- Decode: out[WIDTH-1] = g[WIDTH-1]; out[i] = out[i+1] ^ g[i] for i down to 0.
- Encode: out = b ^ (b >> 1), using a logical shift.
- Input handshake: a transfer occurs when in_valid && in_ready.
- Output handshake: a transfer occurs when out_valid && out_ready.
- Once out_valid rises, out_data, out_mode and out_adj_err hold stable until the output transfer.
- S2 loads when S1 is valid and (S2 is empty or out_ready).
- S1 loads on an input transfer.
- in_ready = !S1_valid || !S2_valid || out_ready. This is a combinational path from out_ready.
- Adjacency history:
  - Registers hist (WIDTH bits) and hist_valid.
  - Updated only when a decode-mode item moves S1→S2. Encode items neither check nor modify the history.
- Adjacency check for a decode item moving S1→S2:
  - out_adj_err = hist_valid && (popcount(g ^ hist) != 1).
  - Identical consecutive codes therefore count as errors.
  - On the same edge, hist ← g and hist_valid ← 1.
- err_count increments on each S1→S2 move carrying adj_err = 1 and saturates at all-ones.
- clr_hist:
  - Clears hist_valid.
  - If it coincides with a decode S1→S2 move, that item reports adj_err = 0 and is loaded as the new history (hist_valid ends at 1).
  - err_count is not cleared by clr_hist.
- Encode items always report out_adj_err = 0.

## Timing
- Reset values (asynchronous, take effect immediately):
  - S1_valid = 0, S2_valid = 0, so out_valid = 0 and in_ready = 1.
  - out_data = 0, out_mode = 0, out_adj_err = 0.
  - hist = 0, hist_valid = 0, err_count = 0.
- Latency: an item accepted at edge k is visible on out_valid after edge k+1, provided the pipeline is not stalled.
- Throughput: one item per cycle while out_ready = 1.
- Full (out_ready = 0): at most 2 items are held. in_ready drops once S1 and S2 are both valid.
- Simultaneous output transfer and S1→S2 move: S2 is replaced on the same edge with no bubble.
- Simultaneous input transfer and S1→S2 move: S1 is refilled on the same edge.
- rst asserted mid-operation: all in-flight items are discarded, with no partial output. First acceptance is possible in the first cycle after deassertion.

## Test plan
- WIDTH = 4, out_ready = 1:
  - decode 4'b1011 → out_data 4'b1101, out_mode 0, on out_valid 2 edges after acceptance.
  - encode 4'b1101 → 4'b1011.
- Decode stream 0000, 0001, 0011, 0010 → out_data 0, 1, 2, 3; out_adj_err 0 on every item; err_count 0.
- Continue with decode 0111 (two bits differ from 0010) → out_adj_err 1, err_count 1.
  - Then decode 0111 again → out_adj_err 1 (identical code), err_count 2.
- Pulse clr_hist in the same cycle the item 1000 moves S1→S2 → out_adj_err 0.
  - Next decode 1001 → adj_err 0.
  - An interleaved encode item leaves the history untouched.
- Hold out_ready = 0 and offer 3 items:
  - Exactly 2 accepted, then in_ready = 0; out_data stays stable.
  - Release out_ready → items emerge in order, one per cycle, with no loss or duplication.
- With ERR_CNT_W = 2, force 5 adjacency errors → err_count saturates at 3.
- Assert rst asynchronously with both stages full → out_valid = 0 and err_count = 0 before the next edge.
  - After release, a fresh decode 0001 reports adj_err 0.
